// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and helpers for the mux select sequencer.
// Holds the FSM state encoding and the select start/end index helpers
// used by both the top level and the select counter.
package mux_select_sequencer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // First select index of a word: 0 for LSB-first, width-1 for MSB-first.
  function automatic int unsigned sel_first_idx(input int unsigned width, input bit msb_first);
    return msb_first ? (width - 1) : 0;
  endfunction

  // Last select index of a word: the opposite end from sel_first_idx.
  function automatic int unsigned sel_last_idx(input int unsigned width, input bit msb_first);
    return msb_first ? 0 : (width - 1);
  endfunction

endpackage

// File: rtl/mux_select_sequencer_sel_counter.sv
// Select counter: walks the mux select from the start index to the last index.
// Latency: sel updates on the clock edge after load_i/step_i.
// Backpressure: holds sel while step_i is low; never wraps past the last index.
module mux_select_sequencer_sel_counter
  import mux_select_sequencer_pkg::*;
#(
  parameter int SEL_W     = 3,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  output logic [SEL_W-1:0] sel_o,
  output logic             at_last_o
);

  localparam int unsigned      NUM_SEL = 1 << SEL_W;
  localparam logic [SEL_W-1:0] SEL_FIRST = SEL_W'(sel_first_idx(NUM_SEL, MSB_FIRST));
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(sel_last_idx(NUM_SEL, MSB_FIRST));
  localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);

  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;

  assign sel_o     = sel_q;
  assign at_last_o = (sel_q == SEL_LAST);

  // Next select: reload wins over step; a step at the last index holds.
  always_comb begin
    sel_d = sel_q;
    if (load_i) begin
      sel_d = SEL_FIRST;
    end else if (step_i && !at_last_o) begin
      sel_d = MSB_FIRST ? (sel_q - SEL_ONE) : (sel_q + SEL_ONE);
    end
  end

  // Select register, synchronously reset to the start index.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= SEL_FIRST;
    end else begin
      sel_q <= sel_d;
    end
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// Serializer front-end for the 8:1 mux: accepts words, steps the select, emits one bit per cycle.
// Latency: a word accepted on edge N has its first bit valid in cycle N+1; no bubble between words.
// Backpressure: bit_ready low freezes select and outputs; in_ready drops only while the pending slot is full.
module mux_select_sequencer
  import mux_select_sequencer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] mux_i,
  output logic [SEL_W-1:0] mux_s,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  input  logic             bit_ready
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             cnt_load, cnt_step;
  logic [SEL_W-1:0] sel;
  logic             at_last;
  logic             accept;
  logic             bit_hs;
  logic             word_done;

  // in_ready looks only at the pending slot, so a stalled consumer never blocks a free slot.
  assign in_ready  = !rst && !pend_full_q;
  assign accept    = in_valid && in_ready;
  assign bit_hs    = bit_valid && bit_ready;
  assign word_done = bit_hs && at_last;

  mux_select_sequencer_sel_counter #(
    .SEL_W     (SEL_W),
    .MSB_FIRST (MSB_FIRST)
  ) u_sel_counter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .step_i    (cnt_step),
    .sel_o     (sel),
    .at_last_o (at_last)
  );

  // State and word registers; reset discards both the current and pending words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
    end
  end

  // Next state: leave SHIFT only when the last bit goes and no word is waiting or arriving.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SHIFT;
      ST_SHIFT: if (word_done && !pend_full_q && !accept) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Word handoff: pending word first, then a same-cycle bypass, otherwise park arrivals in pend.
  always_comb begin
    cur_d       = cur_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_d    = in_data;
          cnt_load = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (word_done) begin
          if (pend_full_q) begin
            // in_ready was low this cycle, so no new word competes with pend.
            cur_d       = pend_q;
            pend_full_d = 1'b0;
            cnt_load    = 1'b1;
          end else if (accept) begin
            cur_d    = in_data;
            cnt_load = 1'b1;
          end
        end else begin
          cnt_step = bit_hs;
          if (accept) begin
            pend_d      = in_data;
            pend_full_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  // Outputs: mux drive straight from the registers, serial bit taken from the current word.
  always_comb begin
    mux_i     = cur_q;
    mux_s     = sel;
    bit_out   = cur_q[sel];
    bit_valid = (state_q == ST_SHIFT);
    bit_last  = (state_q == ST_SHIFT) && at_last;
  end

endmodule

// File: tb/tb_mux_select_sequencer.sv
module tb_mux_select_sequencer;

  typedef struct packed {
    logic [7:0] w;
    logic [2:0] s;
    logic       b;
    logic       l;
  } exp_t;

  logic       clk;
  logic       rst;

  logic [7:0] in_data;
  logic       in_valid, in_ready;
  logic [7:0] mux_i;
  logic [2:0] mux_s;
  logic       bit_out, bit_valid, bit_last, bit_ready;

  logic [7:0] d1_in_data;
  logic       d1_in_valid, d1_in_ready;
  logic [7:0] d1_mux_i;
  logic [2:0] d1_mux_s;
  logic       d1_bit_out, d1_bit_valid, d1_bit_last, d1_bit_ready;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  exp_t q0[$];
  exp_t q1[$];

  mux_select_sequencer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mux_i(mux_i), .mux_s(mux_s),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_last(bit_last), .bit_ready(bit_ready)
  );

  mux_select_sequencer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst),
    .in_data(d1_in_data), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
    .mux_i(d1_mux_i), .mux_s(d1_mux_s),
    .bit_out(d1_bit_out), .bit_valid(d1_bit_valid), .bit_last(d1_bit_last), .bit_ready(d1_bit_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_total++;
    assert (obs === exp_v) checks_passed++;
    else begin
      checks_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for the last-bit handshake of the LSB-first instance; ends at that cycle's negedge.
  task automatic wait_last0(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bit_valid && bit_last && bit_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Scoreboard for the LSB-first instance: expectations pushed on accept, popped on bit handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q0.delete();
    end else begin
      if (bit_valid && bit_ready) begin
        chk("sb0_nonempty", (q0.size() != 0), 1);
        if (q0.size() != 0) begin
          e = q0.pop_front();
          chk("sb0_bit", bit_out, e.b);
          chk("sb0_sel", mux_s, e.s);
          chk("sb0_last", bit_last, e.l);
          chk("sb0_word", mux_i, e.w);
        end
      end
      if (in_valid && in_ready) begin
        for (int i = 0; i < 8; i++) begin
          e.w = in_data; e.s = 3'(i); e.b = in_data[i]; e.l = (i == 7);
          q0.push_back(e);
        end
      end
    end
  end

  // Scoreboard for the MSB-first instance: select order 7..0, last at select 0.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q1.delete();
    end else begin
      if (d1_bit_valid && d1_bit_ready) begin
        chk("sb1_nonempty", (q1.size() != 0), 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("sb1_bit", d1_bit_out, e.b);
          chk("sb1_sel", d1_mux_s, e.s);
          chk("sb1_last", d1_bit_last, e.l);
          chk("sb1_word", d1_mux_i, e.w);
        end
      end
      if (d1_in_valid && d1_in_ready) begin
        for (int i = 7; i >= 0; i--) begin
          e.w = d1_in_data; e.s = 3'(i); e.b = d1_in_data[i]; e.l = (i == 0);
          q1.push_back(e);
        end
      end
    end
  end

  initial begin
    bit ok;
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; bit_ready = 1'b1;
    d1_in_data = '0; d1_in_valid = 1'b0; d1_bit_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_bit_last", bit_last, 0);
    chk("rst_mux_s", mux_s, 0);
    chk("rst_mux_i", mux_i, 0);
    chk("rst_msb_mux_s", d1_mux_s, 7);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // Single word, LSB first
    step();
    in_data = 8'b1100_1100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_first_valid", bit_valid, 1);
    chk("t1_first_sel", mux_s, 0);
    wait_last0(ok);
    chk("t1_last_seen", ok, 1);
    chk("t1_last_sel", mux_s, 7);
    step();
    @(negedge clk);
    chk("t1_idle_valid", bit_valid, 0);
    chk("t1_idle_last", bit_last, 0);
    chk("t1_hold_mux_i", mux_i, 8'hCC);
    chk("t1_hold_sel", mux_s, 7);

    // Single word, MSB first
    step();
    d1_in_data = 8'b1100_1100; d1_in_valid = 1'b1;
    step();
    d1_in_valid = 1'b0;
    @(negedge clk);
    chk("t2_first_sel", d1_mux_s, 7);
    chk("t2_first_bit", d1_bit_out, 1);
    repeat (7) step();
    @(negedge clk);
    chk("t2_last_sel", d1_mux_s, 0);
    chk("t2_last_flag", d1_bit_last, 1);
    step();
    @(negedge clk);
    chk("t2_idle_valid", d1_bit_valid, 0);

    // Back-to-back words: 16 gap-free bits, in_ready low while pend holds 8'h3C
    step();
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_data = 8'h3C;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("t3_valid", bit_valid, 1);
      chk("t3_in_ready", in_ready, (k >= 1 && k <= 7) ? 0 : 1);
      chk("t3_last", bit_last, (k == 7 || k == 15) ? 1 : 0);
      if (k == 8) begin
        chk("t3_second_sel", mux_s, 0);
        chk("t3_second_word", mux_i, 8'h3C);
      end
      step();
      if (k == 0) in_valid = 1'b0;
    end
    @(negedge clk);
    chk("t3_idle_valid", bit_valid, 0);

    // Backpressure: bit_ready low for 3 cycles at select 4
    step();
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    bit_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t4_hold_sel", mux_s, 4);
      chk("t4_hold_bit", bit_out, 1);
      chk("t4_hold_valid", bit_valid, 1);
      chk("t4_hold_word", mux_i, 8'h5A);
      step();
    end
    bit_ready = 1'b1;
    @(negedge clk);
    chk("t4_still_sel4", mux_s, 4);
    step();
    @(negedge clk);
    chk("t4_resume_sel", mux_s, 5);
    wait_last0(ok);
    chk("t4_last_seen", ok, 1);
    step();
    @(negedge clk);
    chk("t4_idle_valid", bit_valid, 0);

    // Bypass: new word offered in the last-bit cycle with pend empty
    step();
    in_data = 8'h0F; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (7) step();
    in_data = 8'hF0; in_valid = 1'b1;
    @(negedge clk);
    chk("t5_last_cycle", bit_last, 1);
    chk("t5_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t5_no_idle", bit_valid, 1);
    chk("t5_sel_restart", mux_s, 0);
    chk("t5_word", mux_i, 8'hF0);
    wait_last0(ok);
    chk("t5_last_seen", ok, 1);
    step();
    @(negedge clk);
    chk("t5_idle_valid", bit_valid, 0);

    // Reset at select 3 with the pending slot full
    step();
    in_data = 8'h81; in_valid = 1'b1;
    step();
    in_data = 8'h7E;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("t6_pend_full", in_ready, 0);
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_sel_at_rst", mux_s, 3);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", bit_valid, 0);
    chk("t6_last", bit_last, 0);
    chk("t6_sel", mux_s, 0);
    chk("t6_mux_i", mux_i, 0);
    chk("t6_pend_cleared", in_ready, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      @(negedge clk);
      chk("t6_no_resume", bit_valid, 0);
    end

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
